// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, inst} buffer that parks a fetched instruction while decode stalls.
module fetch_hold_buf #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INST_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  capture_i,
    input  logic                  clear_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    output logic                  vld_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [INST_WIDTH-1:0] inst_o
);

    logic                  vld_q, vld_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;

    // Clear wins so a redirect always flushes a simultaneous capture.
    always_comb begin
        vld_d  = vld_q;
        pc_d   = pc_q;
        inst_d = inst_q;
        if (clear_i) begin
            vld_d = 1'b0;
        end else if (capture_i) begin
            vld_d  = 1'b1;
            pc_d   = pc_i;
            inst_d = inst_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            pc_q   <= '0;
            inst_q <= '0;
        end else begin
            vld_q  <= vld_d;
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    assign vld_o  = vld_q;
    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem and feeds decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter int unsigned         INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  imem_req_o,
    output logic [PC_WIDTH-1:0]   imem_addr_o,
    input  logic [INST_WIDTH-1:0] imem_rdata_i,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  valid_o
);

    localparam logic [PC_WIDTH-1:0] PcIncr   = PC_WIDTH'(PC_INCR);
    localparam logic [PC_WIDTH-1:0] AlignMsk = ~PC_WIDTH'(3);

    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                  inflight_vld_q, inflight_vld_d;
    logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;

    logic                  hold_vld;
    logic [PC_WIDTH-1:0]   hold_pc;
    logic [INST_WIDTH-1:0] hold_inst;
    logic                  hold_capture, hold_clear;

    logic                  redirect_act;
    logic                  req;
    logic [PC_WIDTH-1:0]   req_addr;
    logic [PC_WIDTH-1:0]   target;

    assign target       = redirect_pc_i & AlignMsk;
    assign redirect_act = redirect_i & (state_q != StBoot);

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        inflight_vld_d = 1'b0;
        inflight_pc_d  = inflight_pc_q;
        req            = 1'b0;
        req_addr       = fetch_pc_q;
        hold_capture   = 1'b0;
        hold_clear     = 1'b0;

        if (state_q == StBoot) begin
            req        = 1'b1;
            req_addr   = RESET_PC;
            fetch_pc_d = RESET_PC + PcIncr;
            state_d    = StRun;
        end else if (redirect_act) begin
            req        = 1'b1;
            req_addr   = target;
            fetch_pc_d = target + PcIncr;
            hold_clear = 1'b1;
            state_d    = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (!stall_i) begin
                        req        = 1'b1;
                        fetch_pc_d = fetch_pc_q + PcIncr;
                    end else if (inflight_vld_q) begin
                        hold_capture = 1'b1;
                        state_d      = StHold;
                    end
                end
                StHold: begin
                    // Releasing cycle only drains the buffer; the refetch starts next cycle.
                    if (!stall_i) begin
                        hold_clear = 1'b1;
                        state_d    = StRun;
                    end
                end
                default: state_d = StBoot;
            endcase
        end

        if (req) begin
            inflight_vld_d = 1'b1;
            inflight_pc_d  = req_addr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StBoot;
            fetch_pc_q     <= RESET_PC;
            inflight_vld_q <= 1'b0;
            inflight_pc_q  <= RESET_PC;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_pc_q  <= inflight_pc_d;
        end
    end

    fetch_hold_buf #(
        .PC_WIDTH  (PC_WIDTH),
        .INST_WIDTH(INST_WIDTH)
    ) u_hold_buf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .capture_i(hold_capture),
        .clear_i  (hold_clear),
        .pc_i     (inflight_pc_q),
        .inst_i   (imem_rdata_i),
        .vld_o    (hold_vld),
        .pc_o     (hold_pc),
        .inst_o   (hold_inst)
    );

    // BOOT state would otherwise request while reset is still held.
    assign imem_req_o  = req & ~rst_i;
    assign imem_addr_o = req_addr;

    assign valid_o = (hold_vld | inflight_vld_q) & ~redirect_i;
    assign pc_o    = hold_vld ? hold_pc : inflight_pc_q;
    assign inst_o  = !valid_o ? INST_WIDTH'(INST_NOP) :
                     hold_vld ? hold_inst : imem_rdata_i;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed and random stall/redirect against a stream model.
module tb_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, valid;
    logic [31:0] imem_addr, imem_rdata, pc, inst;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_rdata, w_pc, w_inst;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the stage should present in the coming cycle.
    logic        m_boot, m_shown_vld, m_held;
    logic [31:0] m_shown_pc, m_nxt, m_stream;
    int          w_k;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        imem_rdata <= memf(imem_addr);
        w_rdata    <= memf(w_addr);
    end

    fetch_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .pc_o         (pc),
        .inst_o       (inst),
        .valid_o      (valid)
    );

    fetch_stage #(
        .RESET_PC(WRAP_PC)
    ) dut_w (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (1'b0),
        .redirect_i   (1'b0),
        .redirect_pc_i(32'h0),
        .imem_req_o   (w_req),
        .imem_addr_o  (w_addr),
        .imem_rdata_i (w_rdata),
        .pc_o         (w_pc),
        .inst_o       (w_inst),
        .valid_o      (w_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot      = 1'b1;
        m_shown_vld = 1'b0;
        m_held      = 1'b0;
        m_shown_pc  = RST_PC;
        m_nxt       = RST_PC;
        m_stream    = RST_PC;
        w_k         = 0;
    endtask

    task automatic chk_in_reset();
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, NOP);
        chk("rst_w_pc", w_pc, WRAP_PC);
    endtask

    // Called at a falling edge; leaves at the next falling edge.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc);
        logic        ev, ereq;
        logic [31:0] t, eaddr;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
        t  = rpc & 32'hFFFF_FFFC;
        ev = m_shown_vld & ~r & ~m_boot;
        eaddr = m_nxt;
        if (m_boot) begin
            ereq = 1'b1; eaddr = RST_PC;
        end else if (r) begin
            ereq = 1'b1; eaddr = t;
        end else if (m_held || s) begin
            ereq = 1'b0;
        end else begin
            ereq = 1'b1;
        end

        chk("valid", {31'b0, valid}, {31'b0, ev});
        chk("req", {31'b0, imem_req}, {31'b0, ereq});
        if (ereq) chk("addr", imem_addr, eaddr);
        if (ev) begin
            chk("pc", pc, m_shown_pc);
            chk("inst", inst, memf(m_shown_pc));
        end else begin
            chk("inst_nop", inst, NOP);
        end
        // Every instruction decode accepts must continue program order.
        if (ev && !s) begin
            chk("order", pc, m_stream);
            m_stream = m_stream + 32'd4;
        end

        if (w_k == 0) begin
            chk("w_boot_valid", {31'b0, w_valid}, 32'h0);
            chk("w_boot_addr", w_addr, WRAP_PC);
        end else if (w_k <= 5) begin
            chk("w_valid", {31'b0, w_valid}, 32'h1);
            chk("w_pc", w_pc, WRAP_PC + 32'(4 * (w_k - 1)));
        end
        w_k++;

        if (m_boot) begin
            m_boot      = 1'b0;
            m_shown_vld = 1'b1;
            m_shown_pc  = RST_PC;
            m_nxt       = RST_PC + 32'd4;
        end else if (r) begin
            m_shown_vld = 1'b1;
            m_shown_pc  = t;
            m_nxt       = t + 32'd4;
            m_held      = 1'b0;
            m_stream    = t;
        end else if (m_held) begin
            if (!s) begin
                m_shown_vld = 1'b0;
                m_held      = 1'b0;
            end
        end else if (s) begin
            if (m_shown_vld) m_held = 1'b1;
        end else begin
            m_shown_vld = 1'b1;
            m_shown_pc  = m_nxt;
            m_nxt       = m_nxt + 32'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        rst         = 1'b1;
        model_reset();
        #12;
        chk_in_reset();
        @(negedge clk);
        rst = 1'b0;

        // Boot, pc 0, pc 4; then stall three cycles on pc 8 and release.
        repeat (3) step(1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0);

        // Unaligned redirect target, then a couple of sequential fetches.
        step(1'b0, 1'b1, 32'h0000_0103);
        repeat (3) step(1'b0, 1'b0, 32'h0);

        // Redirect together with stall while the hold buffer is full.
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b0, 32'h0);

        // PC wrap on the main instance.
        step(1'b0, 1'b1, 32'hFFFF_FFF6);
        repeat (4) step(1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom);
        end

        // Asynchronous reset with a redirect pending.
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        #2;
        rst = 1'b1;
        #1;
        chk_in_reset();
        @(negedge clk);
        chk_in_reset();
        rst      = 1'b0;
        redirect = 1'b0;
        model_reset();
        repeat (6) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
